// File: rtl/mux_2_select_arbiter_if.sv
// rtl/mux_2_select_arbiter_if.sv - request/grant and multiplexer control bundle for mux_2_select_arbiter
interface mux_2_select_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       mux_enable;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    output grant, select, mux_enable, busy, timeout
  );

  modport slave (
    output req,
    input  grant, select, mux_enable, busy, timeout
  );
endinterface

// File: rtl/mux_2_select_arbiter.sv
// rtl/mux_2_select_arbiter.sv - round-robin owner sequencer for the shared 4:1 mux with turnaround and hold limit
module mux_2_select_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_2_select_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic       LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel, sel_n;
  logic [7:0] hold_cnt, hold_n;
  logic [3:0] grant, grant_n;
  logic       mux_en, mux_en_n;
  logic       busy, busy_n;
  logic       timeout, timeout_n;
  logic       start;
  logic [1:0] win;
  logic       others;

  // Scan from the far end toward ptr so the nearest requester is the last to overwrite.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign win    = pick(bus.req, ptr);
  assign others = |(bus.req & ~(4'b0001 << sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      hold_cnt <= 8'd0;
      grant    <= 4'b0000;
      mux_en   <= 1'b1;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      mux_en   <= mux_en_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    hold_n    = hold_cnt;
    grant_n   = grant;
    mux_en_n  = mux_en;
    busy_n    = busy;
    timeout_n = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: start = |bus.req;
      GRANT: begin
        if (hold_cnt != 8'hFF) hold_n = hold_cnt + 8'd1;
        if (!bus.req[sel]) begin
          state_n  = GAP;
          grant_n  = 4'b0000;
          mux_en_n = 1'b1;
        end else if (LIMIT_EN && hold_cnt == HOLD_LAST && others) begin
          state_n   = GAP;
          grant_n   = 4'b0000;
          mux_en_n  = 1'b1;
          timeout_n = 1'b1;
        end
      end
      GAP: begin
        if (|bus.req) begin
          start = 1'b1;
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n  = GRANT;
      grant_n  = 4'b0001 << win;
      sel_n    = win;
      mux_en_n = 1'b0;
      busy_n   = 1'b1;
      hold_n   = 8'd0;
      ptr_n    = win + 2'd1;
    end
  end

  assign bus.grant      = grant;
  assign bus.select     = sel;
  assign bus.mux_enable = mux_en;
  assign bus.busy       = busy;
  assign bus.timeout    = timeout;

endmodule

// File: tb/tb_mux_2_select_arbiter.sv
// tb/tb_mux_2_select_arbiter.sv - directed-vector bench for mux_2_select_arbiter
module tb_mux_2_select_arbiter;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  mux_2_select_arbiter_if bus_a ();
  mux_2_select_arbiter_if bus_b ();

  mux_2_select_arbiter #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  mux_2_select_arbiter #(.MAX_HOLD(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic me, input logic b, input logic t);
    check({tag, ".grant"}, 32'(bus_a.grant), 32'(g));
    check({tag, ".select"}, 32'(bus_a.select), 32'(s));
    check({tag, ".mux_enable"}, 32'(bus_a.mux_enable), 32'(me));
    check({tag, ".busy"}, 32'(bus_a.busy), 32'(b));
    check({tag, ".timeout"}, 32'(bus_a.timeout), 32'(t));
  endtask

  initial begin
    int owners [5] = '{0, 1, 2, 3, 0};
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus_a.req = 4'b1111;
    bus_b.req = 4'b0000;

    // reset holds the bus floating even with every requester up
    repeat (3) tick();
    check_a("reset", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_a("first_grant", 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0);
    bus_a.req = 4'b0000;
    tick();
    check_a("first_gap", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_a("first_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);

    // single requester for five cycles
    bus_a.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a($sformatf("single_c%0d", i), 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
      if (i == 4) bus_a.req = 4'b0000;
    end
    tick();
    check_a("single_gap", 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0);
    tick();
    check_a("single_idle", 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0);

    // round robin from ptr=0 after a reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_a.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      logic [1:0] o;
      o  = 2'(owners[i]);
      oh = 4'b0001 << o;
      tick();
      check_a($sformatf("rr%0d_c0", i), oh, o, 1'b0, 1'b1, 1'b0);
      tick();
      check_a($sformatf("rr%0d_c1", i), oh, o, 1'b0, 1'b1, 1'b0);
      bus_a.req[o] = 1'b0;
      tick();
      check_a($sformatf("rr%0d_gap", i), 4'b0000, o, 1'b1, 1'b1, 1'b0);
      bus_a.req[o] = 1'b1;
    end
    bus_a.req = 4'b0000;
    tick();
    check_a("rr_idle", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0);

    // hold limit of 4 with requester 3 joining in the second cycle (ptr=1)
    bus_a.req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_a($sformatf("hold_c%0d", i), 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
      if (i == 1) bus_a.req = 4'b1010;
    end
    tick();
    check_a("hold_gap", 4'b0000, 2'd1, 1'b1, 1'b1, 1'b1);
    tick();
    check_a("hold_next", 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0);
    bus_a.req = 4'b0000;
    tick();
    check_a("hold_rel_gap", 4'b0000, 2'd3, 1'b1, 1'b1, 1'b0);
    tick();

    // sole requester never times out
    bus_a.req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("sole_grant_c%0d", i), 32'(bus_a.grant), 32'h4);
      check($sformatf("sole_timeout_c%0d", i), 32'(bus_a.timeout), 32'h0);
    end
    bus_a.req = 4'b0000;
    tick();
    tick();

    // MAX_HOLD=3: owner 0 drops exactly at the limit while 1 waits
    bus_b.req = 4'b0001;
    tick();
    check("lim3_c0", 32'(bus_b.grant), 32'h1);
    bus_b.req = 4'b0011;
    tick();
    check("lim3_c1", 32'(bus_b.grant), 32'h1);
    tick();
    check("lim3_c2", 32'(bus_b.grant), 32'h1);
    bus_b.req = 4'b0010;
    tick();
    check("lim3_gap_grant", 32'(bus_b.grant), 32'h0);
    check("lim3_gap_timeout", 32'(bus_b.timeout), 32'h0);
    check("lim3_gap_enable", 32'(bus_b.mux_enable), 32'h1);
    tick();
    check("lim3_next", 32'(bus_b.grant), 32'h2);
    tick();
    check("lim3_next_c1", 32'(bus_b.grant), 32'h2);

    // asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(bus_b.grant), 32'h0);
    check("async_select", 32'(bus_b.select), 32'h0);
    check("async_enable", 32'(bus_b.mux_enable), 32'h1);
    check("async_busy", 32'(bus_b.busy), 32'h0);
    check("async_timeout", 32'(bus_b.timeout), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_grant", 32'(bus_b.grant), 32'h2);
    check("post_reset_select", 32'(bus_b.select), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
